// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder and the mult/div sequencer:
// ALUOp classes, funct codes, ALU operation codes, md_op values and FSM states.
package alu_ctrl_pkg;

    // ALUOp classes; the R-type selector is all-ones at whatever ALUOp width is in use
    localparam logic [2:0] ALUOP_R_TYPE = 3'b111;
    localparam int         ALUOP_ADDI   = 1;
    localparam int         ALUOP_ANDI   = 2;
    localparam int         ALUOP_ORI    = 3;
    localparam int         ALUOP_LUI    = 4;

    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;

    localparam logic [3:0] ALU_SLL  = 4'b0000;
    localparam logic [3:0] ALU_SRL  = 4'b0001;
    localparam logic [3:0] ALU_LUI  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_NOP  = 4'b1001;
    localparam logic [3:0] ALU_MFHI = 4'b1010;
    localparam logic [3:0] ALU_MFLO = 4'b1011;

    // md_op is funct[1:0] of the accepted mult/div instruction
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/alu_control_seq_decode.sv
// Combinational {ALUOp, funct} decode: ALU operation code plus mult/div,
// MFHI/MFLO and illegal-funct classification.
module alu_func_decode
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_WIDTH = 3,
    parameter int OP_WIDTH    = 4
) (
    input  logic [ALUOP_WIDTH-1:0] ALUOp,
    input  logic [5:0]             ALUFunction,
    output logic [OP_WIDTH-1:0]    ALUOperation,
    output logic                   is_md,
    output logic                   is_mfhilo,
    output logic                   illegal
);

    logic [3:0] op;

    // NOTE: every output gets a default before the case so no path leaves a latch.
    always_comb begin
        op        = ALU_NOP;
        is_md     = 1'b0;
        is_mfhilo = 1'b0;
        illegal   = 1'b0;
        if (ALUOp == {ALUOP_WIDTH{1'b1}}) begin
            case (ALUFunction)
                FUNCT_ADD:  op = ALU_ADD;
                FUNCT_AND:  op = ALU_AND;
                FUNCT_NOR:  op = ALU_NOR;
                FUNCT_OR:   op = ALU_OR;
                FUNCT_SLL:  op = ALU_SLL;
                FUNCT_SRL:  op = ALU_SRL;
                FUNCT_SUB:  op = ALU_SUB;
                FUNCT_SLT:  op = ALU_SLT;
                FUNCT_MFHI: begin op = ALU_MFHI; is_mfhilo = 1'b1; end
                FUNCT_MFLO: begin op = ALU_MFLO; is_mfhilo = 1'b1; end
                // the ALU idles while the iterative unit does the work
                FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: is_md = 1'b1;
                default:    illegal = 1'b1;
            endcase
        end else begin
            case (ALUOp)
                ALUOP_WIDTH'(ALUOP_ADDI): op = ALU_ADD;
                ALUOP_WIDTH'(ALUOP_ANDI): op = ALU_AND;
                ALUOP_WIDTH'(ALUOP_ORI):  op = ALU_OR;
                ALUOP_WIDTH'(ALUOP_LUI):  op = ALU_LUI;
                default:                  op = ALU_NOP;
            endcase
        end
    end

    assign ALUOperation = OP_WIDTH'(op);

endmodule

// File: rtl/alu_control_seq.sv
// EX-stage ALU control with a multi-cycle mult/div sequencer (MD_ITERS >= 1).
// Define ALU_CTRL_MD_NONBLOCK_EN to let mult/div retire on accept and run in the background.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_WIDTH = 3,
    parameter int OP_WIDTH    = 4,
    parameter int MD_ITERS    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ALUOP_WIDTH-1:0] ALUOp,
    input  logic [5:0]             ALUFunction,
    input  logic                   issue_valid,
    output logic [OP_WIDTH-1:0]    ALUOperation,
    output logic                   md_start,
    output logic [1:0]             md_op,
    output logic                   md_step,
    output logic                   md_busy,
    output logic                   md_done,
    output logic                   hilo_write,
    output logic                   stall,
    output logic                   illegal
);

    localparam int               CNT_W    = $clog2(MD_ITERS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_ITERS - 1);

    md_state_e        state;
    logic [CNT_W-1:0] count;
    logic             is_md;
    logic             is_mfhilo;

    alu_func_decode #(
        .ALUOP_WIDTH (ALUOP_WIDTH),
        .OP_WIDTH    (OP_WIDTH)
    ) u_decode (
        .ALUOp        (ALUOp),
        .ALUFunction  (ALUFunction),
        .ALUOperation (ALUOperation),
        .is_md        (is_md),
        .is_mfhilo    (is_mfhilo),
        .illegal      (illegal)
    );

    assign md_start = issue_valid & is_md & (state == ST_IDLE);

`ifdef ALU_CTRL_MD_NONBLOCK_EN
    // background mode: only HI/LO readers and a second mult/div wait for the unit
    assign stall = issue_valid & (is_mfhilo | is_md) & md_busy;
`else
    // the mult/div itself holds EX until DONE, where it retires
    assign stall = (issue_valid & is_md & (state != ST_DONE))
                 | (issue_valid & is_mfhilo & md_busy);
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            md_op      <= MD_MULT;
            md_step    <= 1'b0;
            md_busy    <= 1'b0;
            md_done    <= 1'b0;
            hilo_write <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (md_start) begin
                        state   <= ST_RUN;
                        md_op   <= ALUFunction[1:0];
                        count   <= CNT_LOAD;
                        md_step <= 1'b1;
                        md_busy <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // a flush (issue_valid low) does not abort the run
                    if (count == '0) begin
                        state      <= ST_DONE;
                        md_step    <= 1'b0;
                        md_done    <= 1'b1;
                        hilo_write <= 1'b1;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    md_done    <= 1'b0;
                    hilo_write <= 1'b0;
                    md_busy    <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    md_step    <= 1'b0;
                    md_done    <= 1'b0;
                    hilo_write <= 1'b0;
                    md_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: decode table plus hand-written mult/div sequences.
// Stall expectations follow ALU_CTRL_MD_NONBLOCK_EN when it is defined.
module tb_alu_control_seq;
    import alu_ctrl_pkg::*;

`ifdef ALU_CTRL_MD_NONBLOCK_EN
    localparam bit NB = 1'b1;
`else
    localparam bit NB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] ALUOp;
    logic [5:0] ALUFunction;
    logic       issue_valid;
    logic       issue_valid1;

    logic [3:0] ALUOperation, ALUOperation1;
    logic       md_start, md_step, md_busy, md_done, hilo_write, stall, illegal;
    logic [1:0] md_op, md_op1;
    logic       md_start1, md_step1, md_busy1, md_done1, hilo_write1, stall1, illegal1;

    alu_control_seq #(.ALUOP_WIDTH(3), .OP_WIDTH(4), .MD_ITERS(32)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .ALUOp        (ALUOp),
        .ALUFunction  (ALUFunction),
        .issue_valid  (issue_valid),
        .ALUOperation (ALUOperation),
        .md_start     (md_start),
        .md_op        (md_op),
        .md_step      (md_step),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .hilo_write   (hilo_write),
        .stall        (stall),
        .illegal      (illegal)
    );

    alu_control_seq #(.ALUOP_WIDTH(3), .OP_WIDTH(4), .MD_ITERS(1)) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .ALUOp        (ALUOp),
        .ALUFunction  (ALUFunction),
        .issue_valid  (issue_valid1),
        .ALUOperation (ALUOperation1),
        .md_start     (md_start1),
        .md_op        (md_op1),
        .md_step      (md_step1),
        .md_busy      (md_busy1),
        .md_done      (md_done1),
        .hilo_write   (hilo_write1),
        .stall        (stall1),
        .illegal      (illegal1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] aluop;
        logic [5:0] funct;
        logic [3:0] op;
        logic       ill;
    } dec_vec_t;

    dec_vec_t dec_tbl[20];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // leaves the bench 1 time unit after a rising edge with both units idle
    task automatic do_reset();
        issue_valid  = 1'b0;
        issue_valid1 = 1'b0;
        reset        = 1'b1;
        #2;
        reset        = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_stall;
        int   seen;

        dec_tbl[0]  = '{3'b111, 6'b100000, 4'b0011, 1'b0};
        dec_tbl[1]  = '{3'b111, 6'b100100, 4'b0101, 1'b0};
        dec_tbl[2]  = '{3'b111, 6'b100111, 4'b0111, 1'b0};
        dec_tbl[3]  = '{3'b111, 6'b100101, 4'b1000, 1'b0};
        dec_tbl[4]  = '{3'b111, 6'b000000, 4'b0000, 1'b0};
        dec_tbl[5]  = '{3'b111, 6'b000010, 4'b0001, 1'b0};
        dec_tbl[6]  = '{3'b111, 6'b100010, 4'b0100, 1'b0};
        dec_tbl[7]  = '{3'b111, 6'b101010, 4'b0110, 1'b0};
        dec_tbl[8]  = '{3'b111, 6'b010000, 4'b1010, 1'b0};
        dec_tbl[9]  = '{3'b111, 6'b010010, 4'b1011, 1'b0};
        dec_tbl[10] = '{3'b111, 6'b011000, 4'b1001, 1'b0};
        dec_tbl[11] = '{3'b111, 6'b011011, 4'b1001, 1'b0};
        dec_tbl[12] = '{3'b111, 6'b111111, 4'b1001, 1'b1};
        dec_tbl[13] = '{3'b111, 6'b000001, 4'b1001, 1'b1};
        dec_tbl[14] = '{3'b001, 6'b111111, 4'b0011, 1'b0};
        dec_tbl[15] = '{3'b010, 6'b100010, 4'b0101, 1'b0};
        dec_tbl[16] = '{3'b011, 6'b000000, 4'b1000, 1'b0};
        dec_tbl[17] = '{3'b100, 6'b101010, 4'b0010, 1'b0};
        dec_tbl[18] = '{3'b100, 6'b111111, 4'b0010, 1'b0};
        dec_tbl[19] = '{3'b000, 6'b111111, 4'b1001, 1'b0};

        reset        = 1'b1;
        issue_valid  = 1'b0;
        issue_valid1 = 1'b0;
        ALUOp        = 3'b000;
        ALUFunction  = 6'b000000;
        @(posedge clk);
        #1;
        check("reset_regs", {md_op, md_step, md_busy, md_done, hilo_write}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // decode table, issue_valid low so the sequencer stays idle
        for (int i = 0; i < 20; i++) begin
            ALUOp       = dec_tbl[i].aluop;
            ALUFunction = dec_tbl[i].funct;
            #2;
            check($sformatf("dec[%0d]", i), {ALUOperation, illegal}, {dec_tbl[i].op, dec_tbl[i].ill});
        end

        // MULT held: accept c0, RUN c1..32, DONE c33, re-accept c34
        do_reset();
        ALUOp       = 3'b111;
        ALUFunction = FUNCT_MULT;
        issue_valid = 1'b1;
        for (int c = 0; c <= 34; c++) begin
            #4;
            exp_stall = NB ? (c >= 1 && c <= 33) : (c <= 32 || c == 34);
            check($sformatf("mult c%0d", c), {md_start, md_step, md_done, hilo_write, md_busy, stall},
                  {(c == 0 || c == 34), (c >= 1 && c <= 32), (c == 33), (c == 33), (c >= 1 && c <= 33), exp_stall});
            if (c == 33) check("mult md_op", md_op, 32'h0);
            @(posedge clk);
            #1;
        end

        // DIVU then MFLO while busy: MFLO stalls until IDLE
        do_reset();
        ALUFunction = FUNCT_DIVU;
        issue_valid = 1'b1;
        #4;
        check("divu accept", {md_start, stall}, {1'b1, ~NB});
        @(posedge clk);
        #1;
        ALUFunction = FUNCT_MFLO;
        for (int c = 1; c <= 34; c++) begin
            #4;
            check($sformatf("mflo c%0d", c), {md_busy, stall}, {(c <= 33), (c <= 33)});
            if (c == 1) check("mflo aluop", {ALUOperation, illegal}, {ALU_MFLO, 1'b0});
            if (c == 5) check("divu md_op", md_op, 32'h3);
            @(posedge clk);
            #1;
        end

        // reset in RUN cycle 10 clears everything at once; no late hilo_write
        do_reset();
        ALUFunction = FUNCT_MULTU;
        issue_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
        end
        #2;
        check("multu run10", {md_op, md_step, md_busy}, {2'b01, 1'b1, 1'b1});
        reset       = 1'b1;
        issue_valid = 1'b0;
        #1;
        check("async abort", {md_op, md_step, md_busy, md_done, hilo_write}, 32'h0);
        #1;
        reset = 1'b0;
        seen  = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #5;
            if (hilo_write || md_busy) seen++;
        end
        check("post abort quiet", seen, 32'd0);

        // DIV flushed in RUN cycle 5 still completes
        do_reset();
        ALUFunction = FUNCT_DIV;
        issue_valid = 1'b1;
        for (int c = 0; c <= 34; c++) begin
            if (c == 5) issue_valid = 1'b0;
            #4;
            check($sformatf("flush c%0d", c), {md_step, md_done, hilo_write, md_busy},
                  {(c >= 1 && c <= 32), (c == 33), (c == 33), (c >= 1 && c <= 33)});
            if (c == 33) check("div md_op", md_op, 32'h2);
            @(posedge clk);
            #1;
        end

        // MD_ITERS=1: accept, one RUN, DONE, back to IDLE
        do_reset();
        ALUFunction  = FUNCT_MULT;
        issue_valid1 = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            #4;
            check($sformatf("iters1 c%0d", c), {md_start1, md_step1, md_done1, hilo_write1, md_busy1, stall1},
                  {(c == 0), (c == 1), (c == 2), (c == 2), (c == 1 || c == 2), (c == 0) & ~NB});
            @(posedge clk);
            #1;
            issue_valid1 = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Parametrised successor to the combinational ALU control decoder; sits in EX between main control and ALU / iterative mult-div datapath.
- Decodes {ALUOp, ALUFunction} to a 4-bit ALU operation code; adds SUB, SLT, MFHI and MFLO.
- Sequences multi-cycle MULT/MULTU/DIV/DIVU through an FSM with an iteration counter, stall generation and HI/LO write strobe.

Parameters:
- ALUOP_WIDTH, 3, width of ALUOp from main control; R-type selector is all-ones.
- OP_WIDTH, 4, width of ALUOperation.
- MD_ITERS, 32, iterations per mult/div; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ALUOp  in  ALUOP_WIDTH  operation class from main control.
- ALUFunction  in  6  instruction funct field.
- issue_valid  in  1  a valid instruction occupies EX this cycle.
- ALUOperation  out  OP_WIDTH  ALU operation code (combinational).
- md_start  out  1  load mult/div operands (combinational pulse).
- md_op  out  2  latched op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- md_step  out  1  advance one mult/div iteration.
- md_busy  out  1  unit in RUN or DONE.
- md_done  out  1  one-cycle completion pulse.
- hilo_write  out  1  write HI/LO from mult/div result.
- stall  out  1  hold IF/ID/EX.
- illegal  out  1  R-type funct not decoded (combinational).

Behaviour:
- Decode (combinational), R-type (ALUOp all-ones):
  - ADD 100000->0011, AND 100100->0101, NOR 100111->0111, OR 100101->1000.
  - SLL 000000->0000, SRL 000010->0001, SUB 100010->0100, SLT 101010->0110.
  - MFHI 010000->1010, MFLO 010010->1011.
  - MULT/MULTU/DIV/DIVU (011000..011011)->1001 (ALU idle); flagged is_md.
- Decode, I-type (funct ignored): ALUOp 001->0011, 010->0101, 011->1000, 100->0010.
- Default 1001; illegal=1 only for an undecoded R-type funct.
- ALUOperation is combinational and independent of state.
- Reset (async): state IDLE, counter 0, md_op 00; md_step, md_busy, md_done, hilo_write = 0.
- FSM IDLE: issue_valid & is_md -> md_start=1, latch md_op=funct[1:0], counter<=MD_ITERS-1, go RUN.
- FSM RUN: md_step=1, md_busy=1, counter decrements; at counter==0, go DONE.
- FSM DONE: md_done=1, hilo_write=1, md_busy=1, go IDLE.
- Latency: accept cycle + MD_ITERS RUN cycles + 1 DONE cycle = MD_ITERS+2 cycles from accept to the IDLE return.
- Blocking stall: stall = issue_valid & is_md & state!=DONE. Asserted from the accept cycle through the last RUN cycle (MD_ITERS+1 cycles); deasserted in DONE so the instruction retires.
- MFHI/MFLO while md_busy -> stall=1 until IDLE.
- issue_valid dropping mid-RUN (flush): the operation completes, hilo_write still fires.
- Reset mid-RUN: abort immediately, no hilo_write.
- md_op is stable from RUN through DONE.
- is_md while in DONE: no new start that cycle; accepted on the following IDLE cycle.
- Counter width: $clog2(MD_ITERS+1).

Optional Feature:
- Macro: ALU_CTRL_MD_NONBLOCK_EN.
- Defined: mult/div does not stall on issue. The instruction retires in its accept cycle and the unit runs in the background.
  - stall=1 only for MFHI/MFLO or a new is_md while md_busy.
  - A new is_md presented in DONE is stalled one cycle.
- Undefined: blocking behaviour as above.

Decomposition:
- Package alu_ctrl_pkg:
  - ALUOp class constants (R_TYPE, ADDI, ANDI, ORI, LUI).
  - funct constants.
  - ALU operation codes (incl. NOP 1001).
  - md_op encodings.
  - FSM state encoding IDLE/RUN/DONE.
- Sub-module alu_func_decode: pure combinational decode producing ALUOperation, is_md, is_mfhilo and illegal.
- alu_control_seq instantiates alu_func_decode and holds the FSM and counter.

Test Plan:
- ALUOp=111, funct 100010 -> ALUOperation 0100; funct 101010 -> 0110; funct 111111 -> 1001 with illegal=1; ALUOp=100, any funct -> 0010 with illegal=0.
- MD_ITERS=32, issue_valid=1 with MULT (011000) held -> md_start in cycle 0; md_step cycles 1..32; md_done/hilo_write in cycle 33; stall in cycles 0..32 only; md_op=00.
- DIVU then MFLO issued while md_busy -> MFLO stall=1 until IDLE; MFLO ALUOperation 1011.
- Reset asserted in RUN cycle 10 -> all registered outputs 0 asynchronously; no hilo_write afterwards; md_busy=0.
- issue_valid dropped in RUN cycle 5 of DIV -> run continues; hilo_write in cycle 33.
- With ALU_CTRL_MD_NONBLOCK_EN: MULT accept cycle stall=0; back-to-back MULT stalls until DONE+1; MD_ITERS=1 gives accept, RUN, DONE in 3 cycles.
